// File: rtl/pwm_actuator.sv
// -----------------------------------------------------------------------------
// pwm_actuator
//
// Turns the coprocessor's duty result (0..100) into a 100-step PWM waveform.
// A new result is staged in a pending register and applied only at a period
// wrap, so each period is either entirely old duty or entirely new duty.
// Dropping enable lets the current period finish before the block goes idle.
//
// Build option:
//   PWM_ACTUATOR_SLEW_LIMIT_EN -- when defined, duty_cur moves toward the
//   pending duty by at most slew_step per wrap (slew_step = 0: full jump).
//   When undefined, duty_cur jumps straight to the pending duty and
//   slew_step is ignored.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst_n        in   synchronous active-low reset
//   enable       in   1 = run, 0 = stop at end of current period
//   valid_in     in   1-cycle strobe, G_in holds a new result
//   G_in[7:0]    in   requested duty, nominal 0..100 (larger is clipped)
//   prescale[7:0] in  clocks per PWM step minus 1
//   slew_step[7:0] in max duty change per period (slew build only)
//   clr_err      in   clears ovr_err
//   pwm_out      out  registered PWM drive
//   duty_cur[7:0] out registered duty currently applied
//   period_tick  out  registered 1-cycle pulse after each period wrap
//   busy         out  1 whenever the FSM is not idle
//   ovr_err      out  registered sticky flag, set when G_in > 100
// -----------------------------------------------------------------------------
module pwm_actuator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       valid_in,
  input  logic [7:0] G_in,
  input  logic [7:0] prescale,
  input  logic [7:0] slew_step,
  input  logic       clr_err,
  output logic       pwm_out,
  output logic [7:0] duty_cur,
  output logic       period_tick,
  output logic       busy,
  output logic       ovr_err
);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  localparam logic [6:0] PH_LAST = 7'd99;
  localparam logic [7:0] DUTY_MAX = 8'd100;

  logic [1:0] r_state;
  logic [7:0] r_psc_cnt;
  logic [6:0] r_ph_cnt;
  logic [7:0] r_duty_pend;
  logic       r_pend;
  logic [7:0] r_duty_cur;
  logic       r_pwm_out;
  logic       r_period_tick;
  logic       r_ovr_err;

  logic       w_active;
  logic       w_step;
  logic       w_wrap;
  logic       w_g_over;
  logic [7:0] w_g_clip;
  logic [7:0] w_duty_nxt;
  logic [1:0] w_state_nxt;

  assign w_active = (r_state != S_OFF);
  assign w_step   = w_active && (r_psc_cnt == prescale);
  assign w_wrap   = w_step && (r_ph_cnt == PH_LAST);
  assign w_g_over = (G_in > DUTY_MAX);
  assign w_g_clip = w_g_over ? DUTY_MAX : G_in;

`ifdef PWM_ACTUATOR_SLEW_LIMIT_EN
  logic       w_up;
  logic [7:0] w_diff;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_up       = (r_duty_pend > r_duty_cur);
    w_diff     = w_up ? (r_duty_pend - r_duty_cur) : (r_duty_cur - r_duty_pend);
    w_duty_nxt = r_duty_pend;
    if ((slew_step != 8'd0) && (w_diff > slew_step)) begin
      w_duty_nxt = w_up ? (r_duty_cur + slew_step) : (r_duty_cur - slew_step);
    end
  end
`else
  logic w_unused_slew;
  assign w_unused_slew = ^slew_step;
  assign w_duty_nxt    = r_duty_pend;
`endif

  // Enable has priority over the wrap in S_STOP, so re-raising enable on the
  // final step of a stopping period keeps the drive running without a gap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OFF:   if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_STOP;
      S_STOP: begin
        if (enable)      w_state_nxt = S_RUN;
        else if (w_wrap) w_state_nxt = S_OFF;
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // is tested inside the clocked block so it is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_OFF;
      r_psc_cnt     <= 8'd0;
      r_ph_cnt      <= 7'd0;
      r_duty_pend   <= 8'd0;
      r_pend        <= 1'b0;
      r_duty_cur    <= 8'd0;
      r_pwm_out     <= 1'b0;
      r_period_tick <= 1'b0;
      r_ovr_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (!w_active) begin
        r_psc_cnt <= 8'd0;
        r_ph_cnt  <= 7'd0;
      end else if (w_step) begin
        r_psc_cnt <= 8'd0;
        r_ph_cnt  <= w_wrap ? 7'd0 : (r_ph_cnt + 7'd1);
      end else begin
        r_psc_cnt <= r_psc_cnt + 8'd1;
      end

      r_period_tick <= w_wrap;
      r_pwm_out     <= w_active && ({1'b0, r_ph_cnt} < r_duty_cur);

      if (w_wrap && r_pend) begin
        r_duty_cur <= w_duty_nxt;
        if (w_duty_nxt == r_duty_pend) r_pend <= 1'b0;
      end

      // Written after the wrap update: a capture on the wrap clock re-arms
      // pend, while the wrap itself used the previously pending duty.
      if (valid_in) begin
        r_duty_pend <= w_g_clip;
        r_pend      <= 1'b1;
      end

      if (valid_in && w_g_over) r_ovr_err <= 1'b1;
      else if (clr_err)         r_ovr_err <= 1'b0;
    end
  end

  assign pwm_out     = r_pwm_out;
  assign duty_cur    = r_duty_cur;
  assign period_tick = r_period_tick;
  assign busy        = w_active;
  assign ovr_err     = r_ovr_err;

endmodule

// File: tb/tb_pwm_actuator.sv
// -----------------------------------------------------------------------------
// tb_pwm_actuator
//
// Self-checking bench for pwm_actuator. A behavioural model tracks the period
// as one clock count (position = count / (prescale+1)) and is compared with
// the DUT after every clock. On top of that: a table of reset / error-flag
// vectors, directed duty, overrange, stop, coincidence and (slew build) slew
// sequences, then randomized segments.
// -----------------------------------------------------------------------------
module tb_pwm_actuator;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       valid_in;
  logic [7:0] G_in;
  logic [7:0] prescale;
  logic [7:0] slew_step;
  logic       clr_err;
  logic       pwm_out;
  logic [7:0] duty_cur;
  logic       period_tick;
  logic       busy;
  logic       ovr_err;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_actuator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .valid_in   (valid_in),
    .G_in       (G_in),
    .prescale   (prescale),
    .slew_step  (slew_step),
    .clr_err    (clr_err),
    .pwm_out    (pwm_out),
    .duty_cur   (duty_cur),
    .period_tick(period_tick),
    .busy       (busy),
    .ovr_err    (ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_mode;      // 0 idle, 1 running, 2 finishing the period
  int m_cnt;       // clocks elapsed in the current period
  int m_pend_val;
  bit m_pend;
  int m_duty;
  bit m_pwm;
  bit m_tick;
  bit m_ovr;

  function automatic int slew_move(input int cur, input int tgt, input int s);
`ifdef PWM_ACTUATOR_SLEW_LIMIT_EN
    if (s == 0) return tgt;
    if (tgt > cur) return (tgt - cur <= s) ? tgt : cur + s;
    return (cur - tgt <= s) ? tgt : cur - s;
`else
    return tgt;
`endif
  endfunction

  task automatic model_step();
    int per;
    bit act;
    bit wrap;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_pend_val = 0; m_pend = 0;
      m_duty = 0; m_pwm = 0; m_tick = 0; m_ovr = 0;
    end else begin
      per  = int'(prescale) + 1;
      act  = (m_mode != 0);
      wrap = act && (m_cnt == 100 * per - 1);
      m_pwm  = act && ((m_cnt / per) < m_duty);
      m_tick = wrap;
      if (wrap && m_pend) begin
        m_duty = slew_move(m_duty, m_pend_val, int'(slew_step));
        if (m_duty == m_pend_val) m_pend = 0;
      end
      if (valid_in) begin
        m_pend_val = (G_in > 8'd100) ? 100 : int'(G_in);
        m_pend     = 1;
      end
      if (valid_in && G_in > 8'd100) m_ovr = 1;
      else if (clr_err)              m_ovr = 0;
      if (!act)      m_cnt = 0;
      else if (wrap) m_cnt = 0;
      else           m_cnt = m_cnt + 1;
      case (m_mode)
        0: if (enable) m_mode = 1;
        1: if (!enable) m_mode = 2;
        default: begin
          if (enable)    m_mode = 1;
          else if (wrap) m_mode = 0;
        end
      endcase
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model and DUT both see the same edge, then compare #1 later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", {19'd0, pwm_out, period_tick, busy, ovr_err, duty_cur},
          {19'd0, m_pwm, m_tick, (m_mode != 0), m_ovr, m_duty[7:0]});
  endtask

  task automatic wait_wrap(input int max_cycles);
    bit seen;
    seen = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (period_tick) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL wrap_timeout: no period_tick within %0d clk", max_cycles);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       valid;
    logic [7:0] g;
    logic       clr;
    logic       exp_busy;
    logic       exp_ovr;
    logic       exp_pwm;
    logic       exp_tick;
    logic [7:0] exp_duty;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int highs;
    int ticks;
    bit all_busy;

    rst_n = 1'b0; enable = 1'b1; valid_in = 1'b0; G_in = 8'd0;
    prescale = 8'd0; slew_step = 8'd0; clr_err = 1'b0;
    m_mode = 0; m_cnt = 0; m_pend_val = 0; m_pend = 0;
    m_duty = 0; m_pwm = 0; m_tick = 0; m_ovr = 0;

    //            rst en vld g       clr busy ovr pwm tick duty
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'd150, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'd200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'd101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    for (int i = 0; i < 13; i++) begin
      rst_n    = vecs[i].rst_n;
      enable   = vecs[i].en;
      valid_in = vecs[i].valid;
      G_in     = vecs[i].g;
      clr_err  = vecs[i].clr;
      tick();
      check($sformatf("vec%0d", i),
            {20'd0, busy, ovr_err, pwm_out, period_tick, duty_cur},
            {20'd0, vecs[i].exp_busy, vecs[i].exp_ovr, vecs[i].exp_pwm,
             vecs[i].exp_tick, vecs[i].exp_duty});
    end
    valid_in = 1'b0; clr_err = 1'b0;

    // ---- duty 40, prescale 0 ----
    do_reset();
    enable = 1'b1; valid_in = 1'b1; G_in = 8'd40;
    tick();
    valid_in = 1'b0;
    wait_wrap(200);
    check("duty40_applied", duty_cur, 8'd40);
    highs = 0; ticks = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      highs += pwm_out;
      ticks += period_tick;
    end
    check("duty40_high_count", highs, 40);
    check("duty40_tick_count", ticks, 1);
    check("duty40_tick_at_100", period_tick, 1'b1);

    // ---- overrange and error flag ----
    valid_in = 1'b1; G_in = 8'd150;
    tick();
    valid_in = 1'b0;
    check("ovr_set", ovr_err, 1'b1);
    wait_wrap(200);
    check("ovr_duty_clip", duty_cur, 8'd100);
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      highs += pwm_out;
    end
    check("duty100_high_count", highs, 100);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ovr_cleared", ovr_err, 1'b0);
    clr_err = 1'b1; valid_in = 1'b1; G_in = 8'd200;
    tick();
    clr_err = 1'b0; valid_in = 1'b0;
    check("ovr_set_wins", ovr_err, 1'b1);
    valid_in = 1'b1; G_in = 8'd40;
    tick();
    valid_in = 1'b0;
    wait_wrap(200);
    check("back_to_40", duty_cur, 8'd40);

    // ---- stop at end of period ----
    wait_wrap(200);
    repeat (30) tick();
    enable = 1'b0;
    all_busy = 1;
    for (int i = 31; i < 100; i++) begin
      tick();
      if (!busy) all_busy = 0;
    end
    check("stop_busy_held", all_busy, 1'b1);
    tick();
    check("stop_wrap_tick", period_tick, 1'b1);
    check("stop_idle", busy, 1'b0);
    repeat (3) tick();
    check("stop_pwm_low", pwm_out, 1'b0);
    check("stop_duty_kept", duty_cur, 8'd40);

    // ---- re-raise enable while stopping ----
    enable = 1'b1;
    tick();
    wait_wrap(200);
    repeat (30) tick();
    enable = 1'b0;
    repeat (30) tick();
    enable = 1'b1;
    all_busy = 1;
    for (int i = 61; i < 100; i++) begin
      tick();
      if (!busy) all_busy = 0;
    end
    tick();
    check("rearm_busy_held", all_busy && busy, 1'b1);
    check("rearm_tick", period_tick, 1'b1);
    repeat (100) tick();
    check("rearm_next_tick", period_tick, 1'b1);

    // ---- capture on the wrap clock ----
    valid_in = 1'b1; G_in = 8'd20;
    tick();
    valid_in = 1'b0;
    repeat (98) tick();
    valid_in = 1'b1; G_in = 8'd70;
    tick();
    valid_in = 1'b0;
    check("coinc_tick", period_tick, 1'b1);
    check("coinc_old_applied", duty_cur, 8'd20);
    repeat (100) tick();
    check("coinc_next_tick", period_tick, 1'b1);
    check("coinc_new_applied", duty_cur, 8'd70);

`ifdef PWM_ACTUATOR_SLEW_LIMIT_EN
    // ---- slew limiting ----
    do_reset();
    slew_step = 8'd25; enable = 1'b1; valid_in = 1'b1; G_in = 8'd100;
    tick();
    valid_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wait_wrap(200);
      check($sformatf("slew_wrap%0d", k), duty_cur, (k >= 4) ? 8'd100 : 8'(25 * k));
    end
    slew_step = 8'd0;
`endif

    // ---- randomized segments ----
    for (int seg = 0; seg < 10; seg++) begin
      rst_n = 1'b0;
      prescale  = 8'($urandom_range(0, 3));
      slew_step = 8'($urandom_range(0, 40));
      tick();
      rst_n  = 1'b1;
      enable = 1'b1;
      for (int c = 0; c < 2000; c++) begin
        if ($urandom_range(0, 149) == 0) enable = ~enable;
        valid_in = ($urandom_range(0, 39) == 0);
        G_in = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(101, 255))
                                           : 8'($urandom_range(0, 100));
        clr_err = ($urandom_range(0, 59) == 0);
        rst_n   = ($urandom_range(0, 799) != 0);
        tick();
      end
      valid_in = 1'b0; clr_err = 1'b0; rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
